rgb_cmp_search: RTL and testbench
=================================

# rgb_cmp_search

Sequential binary-search initiator for the RGB magnitude-comparator interface. It drives the `b` operand of a comparator whose `a` operand holds a hidden value, and samples that comparator's `red` (a≥b), `green` (a≤b) and `blue` (a≠b) flags. It converges on the hidden value in at most WIDTH+1 probes and reports the found value, the probe count, or an error. It sits on the board top level next to the comparator and replaces the switch-driven `b` input.

## Interface
- `WIDTH`, 2, operand width; legal range 1..8.
- `SETTLE`, 1, cycles the block waits after changing `guess` before sampling flags; minimum 1.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: begin a search; sampled in IDLE, DONE and ERR only.
- `red` in 1: comparator flag, a≥b.
- `green` in 1: comparator flag, a≤b.
- `blue` in 1: comparator flag, a≠b.
- `guess` out WIDTH: value driven onto the comparator's `b`.
- `busy` out 1: search in progress.
- `done` out 1: level; search found a match.
- `err` out 1: level; search failed or flags were inconsistent.
- `found` out WIDTH: matched value; valid while `done`=1.
- `steps` out $clog2(WIDTH+2): probes used in the last or current search.

## Operation
- States: IDLE, WAIT, SAMPLE, DONE, ERR.
- IDLE/DONE/ERR with `start`=1:
  - lo=0, hi=2^WIDTH−1, `guess`=(lo+hi)>>1, `steps`=0.
  - Clear `done`, `err` and `found`; set `busy`=1.
  - Settle counter loads SETTLE−1; go to WAIT.
  - `start` is ignored in WAIT and SAMPLE.
- WAIT: if counter=0, go to SAMPLE; otherwise decrement.
- SAMPLE: `steps`+1, then decode the flags into eq/gt/lt:
  - eq (`blue`=0): `found`=`guess`, go to DONE.
  - gt: if `guess`=hi, go to ERR; else lo=`guess`+1.
  - lt: if `guess`=lo, go to ERR; else hi=`guess`−1.
  - On gt or lt without error: `guess`=(lo+hi)>>1 using the updated bounds, reload the counter, go to WAIT.
- Midpoint arithmetic uses WIDTH+1 bits, so lo+hi never overflows.
- DONE: `done`=1, `busy`=0; held until `start` or reset.
- ERR: `err`=1, `busy`=0; held until `start` or reset. `found` holds 0.
- `guess` holds its last value in DONE and ERR.

## Timing
- Reset values: `guess`=0, `busy`=0, `done`=0, `err`=0, `found`=0, `steps`=0. State is IDLE.
- Reset asserted mid-search aborts the search; all outputs take reset values at that edge.
- Flags are sampled combinationally in SAMPLE, exactly SETTLE+1 cycles after `guess` changed.
- Each probe takes SETTLE+1 cycles. `done` or `err` rises P·(SETTLE+1) cycles after the `start` edge, where P is the probe count.
- Worst case: WIDTH+1 probes.
- `start` asserted in DONE or ERR restarts the search; `done`/`err` drop on that same edge.

## Configuration
- `RGB_SEARCH_CHECK_EN` defined:
  - Flag decode validates the flag triple. eq requires `red`=`green`=1 with `blue`=0. gt is `red`=1, `green`=0, `blue`=1. lt is `red`=0, `green`=1, `blue`=1.
  - Any other combination sends SAMPLE to ERR, with `steps` incremented.
- `RGB_SEARCH_CHECK_EN` undefined:
  - eq = `blue`=0.
  - Otherwise gt = `red`, lt = ~`red`. `green` is ignored.
  - Only the bound-exhaustion condition produces ERR.

## Structure
- Package `rgb_search_pkg`:
  - State enum `search_state_t`.
  - Decoded-flag struct `cmp_flags_t` {eq, gt, lt, bad}.
  - Constant `RGB_SEARCH_MAX_WIDTH`=8.
- Sub-module `rgb_flag_decode`: combinational. Maps `red`/`green`/`blue` to `cmp_flags_t`. The `RGB_SEARCH_CHECK_EN` logic lives only here.
- Top holds the FSM, lo/hi registers, settle counter and `steps`.

## Test plan
All cases use WIDTH=2, SETTLE=1, with a behavioural comparator model driven by a hidden value `a`.
- a=2, pulse `start` → probes `guess`=1 then 2; `done`=1, `found`=2, `steps`=2, 4 cycles after start.
- a=3 → probes 1, 2, 3; `done`, `found`=3, `steps`=3, 6 cycles after start.
- a=0 → probes 1, 0; `done`, `found`=0, `steps`=2.
- Flags forced to `red`=0, `green`=0, `blue`=1:
  - With the macro: `err`=1 after the first probe, `steps`=1.
  - Without the macro: lt path, probes 1 then 0, then `err`=1, `steps`=2.
- `rst_n`=0 during the second WAIT of a=3 → next edge shows IDLE, all outputs 0. Re-`start` completes normally with `found`=3.
- `start` held high throughout a=2 → ignored while `busy`. After DONE it restarts on the next edge: `done` drops, `guess`=1.

Source files
------------

// File: rtl/rgb_search_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rgb_search_pkg : shared types for the RGB comparator search block  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rgb_search_pkg;

  localparam int RGB_SEARCH_MAX_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SAMPLE = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } search_state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
    logic bad;
  } cmp_flags_t;

endpackage : rgb_search_pkg
`default_nettype wire

// File: rtl/rgb_flag_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rgb_flag_decode : maps red/green/blue comparator flags to eq/gt/lt |
// | Strict triple validation when RGB_SEARCH_CHECK_EN is defined.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rgb_flag_decode
  import rgb_search_pkg::*;
(
  input  logic       red,
  input  logic       green,
  input  logic       blue,
  output cmp_flags_t flags
);

`ifdef RGB_SEARCH_CHECK_EN
  logic w_eq;
  logic w_gt;
  logic w_lt;

  assign w_eq = red & green & ~blue;
  assign w_gt = red & ~green & blue;
  assign w_lt = ~red & green & blue;

  assign flags.eq  = w_eq;
  assign flags.gt  = w_gt;
  assign flags.lt  = w_lt;
  assign flags.bad = ~(w_eq | w_gt | w_lt);
`else
  // green carries no extra information once blue and red are known
  logic w_unused_green;
  assign w_unused_green = green;

  assign flags.eq  = ~blue;
  assign flags.gt  = blue & red;
  assign flags.lt  = blue & ~red;
  assign flags.bad = 1'b0;
`endif

endmodule : rgb_flag_decode
`default_nettype wire

// File: rtl/rgb_cmp_search.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rgb_cmp_search : binary-search initiator driving a comparator's b  |
// | Flag checking selected by RGB_SEARCH_CHECK_EN (in rgb_flag_decode). |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rgb_cmp_search
  import rgb_search_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          red,
  input  logic                          green,
  input  logic                          blue,
  output logic [WIDTH-1:0]              guess,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [WIDTH-1:0]              found,
  output logic [$clog2(WIDTH+2)-1:0]    steps
);

  localparam int SW = $clog2(WIDTH + 2);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0]    c_settle_load = CW'(SETTLE - 1);
  localparam logic [WIDTH-1:0] c_hi_init     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_mid_init    = c_hi_init >> 1;

  search_state_t    r_state, w_state_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_guess, w_guess_nxt;
  logic [WIDTH-1:0] r_found, w_found_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [SW-1:0]    r_steps, w_steps_nxt;
  logic [WIDTH:0]   w_mid_sum;
  cmp_flags_t       w_flags;

  rgb_flag_decode u_decode (
    .red   (red),
    .green (green),
    .blue  (blue),
    .flags (w_flags)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lo    <= '0;
      r_hi    <= '0;
      r_guess <= '0;
      r_found <= '0;
      r_cnt   <= '0;
      r_steps <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_guess <= w_guess_nxt;
      r_found <= w_found_nxt;
      r_cnt   <= w_cnt_nxt;
      r_steps <= w_steps_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_guess_nxt = r_guess;
    w_found_nxt = r_found;
    w_cnt_nxt   = r_cnt;
    w_steps_nxt = r_steps;
    w_mid_sum   = '0;

    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_state_nxt = S_WAIT;
          w_lo_nxt    = '0;
          w_hi_nxt    = c_hi_init;
          w_guess_nxt = c_mid_init;
          w_found_nxt = '0;
          w_steps_nxt = '0;
          w_cnt_nxt   = c_settle_load;
        end
      end

      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end

      S_SAMPLE: begin
        w_steps_nxt = r_steps + SW'(1);
        if (w_flags.bad) begin
          w_state_nxt = S_ERR;
        end else if (w_flags.eq) begin
          w_found_nxt = r_guess;
          w_state_nxt = S_DONE;
        end else if ((w_flags.gt && (r_guess == r_hi)) ||
                     (!w_flags.gt && (r_guess == r_lo))) begin
          // bounds exhausted: hidden value cannot lie in [lo, hi]
          w_state_nxt = S_ERR;
        end else begin
          if (w_flags.gt) begin
            w_lo_nxt = r_guess + WIDTH'(1);
          end else begin
            w_hi_nxt = r_guess - WIDTH'(1);
          end
          // extra sum bit keeps lo+hi from wrapping at full range
          w_mid_sum   = {1'b0, w_lo_nxt} + {1'b0, w_hi_nxt};
          w_guess_nxt = w_mid_sum[WIDTH:1];
          w_cnt_nxt   = c_settle_load;
          w_state_nxt = S_WAIT;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign guess = r_guess;
  assign found = r_found;
  assign steps = r_steps;
  assign busy  = (r_state == S_WAIT) || (r_state == S_SAMPLE);
  assign done  = (r_state == S_DONE);
  assign err   = (r_state == S_ERR);

endmodule : rgb_cmp_search
`default_nettype wire

// File: tb/tb_rgb_cmp_search.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rgb_cmp_search : scoreboard bench with a comparator model       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_rgb_cmp_search;

  localparam int W  = 2;
  localparam int ST = 1;
  localparam int P  = ST + 1;
`ifdef RGB_SEARCH_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam int K_DONE  = 0;
  localparam int K_ERR   = 1;
  localparam int K_RESET = 2;

  typedef struct {
    int       kind;
    int       start_cyc;
    int       found;
    int       steps;
    int       nprobes;
    int       probes [0:W];
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         red, green, blue;
  logic [W-1:0] guess;
  logic         busy, done, err;
  logic [W-1:0] found;
  logic [$clog2(W+2)-1:0] steps;

  int  hidden;
  bit  force_bad;
  int  cyc;
  int  n_checks;
  int  n_fail;
  exp_t exp_q [$];

  rgb_cmp_search #(.WIDTH(W), .SETTLE(ST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .red   (red),
    .green (green),
    .blue  (blue),
    .guess (guess),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .found (found),
    .steps (steps)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural comparator holding the hidden a operand
  always_comb begin
    if (force_bad) begin
      red = 1'b0; green = 1'b0; blue = 1'b1;
    end else begin
      red   = (hidden >= int'(guess));
      green = (hidden <= int'(guess));
      blue  = (hidden != int'(guess));
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic exp_t model(input int a, input bit fb, input int sc);
    exp_t e;
    int lo, hi, g;
    bit fin;
    e.kind = K_DONE; e.start_cyc = sc; e.found = 0; e.steps = 0; e.nprobes = 0;
    for (int i = 0; i <= W; i++) e.probes[i] = 0;
    lo = 0; hi = (1 << W) - 1; fin = 0;
    while (!fin && e.steps <= W) begin
      g = (lo + hi) / 2;
      e.probes[e.nprobes] = g;
      e.nprobes++;
      e.steps++;
      if (fb && CHK) begin
        e.kind = K_ERR; fin = 1;
      end else if (!fb && a == g) begin
        e.kind = K_DONE; e.found = g; fin = 1;
      end else if (!fb && a > g) begin
        if (g == hi) begin e.kind = K_ERR; fin = 1; end
        else lo = g + 1;
      end else begin
        if (g == lo) begin e.kind = K_ERR; fin = 1; end
        else hi = g - 1;
      end
    end
    return e;
  endfunction

  // monitor: pops expectations as the DUT reaches them
  initial begin : monitor
    exp_t e;
    bit   prev_term;
    int   d;
    prev_term = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (exp_q.size() > 0 && exp_q[0].kind == K_RESET) begin
        if (cyc >= exp_q[0].start_cyc) begin
          chk("reset_outputs", int'({guess, found, steps, busy, done, err}), 0);
          void'(exp_q.pop_front());
        end
      end else begin
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          d = cyc - e.start_cyc;
          if (d == 0)
            chk("start_flags_busy_done_err", int'({busy, done, err}), 4);
          if (d >= 0 && (d % P) == 0 && (d / P) < e.nprobes)
            chk("probe_guess", int'(guess), e.probes[d / P]);
        end
        if ((done || err) && !prev_term) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_termination", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("term_err", int'(err), (e.kind == K_ERR) ? 1 : 0);
            chk("term_done", int'(done), (e.kind == K_DONE) ? 1 : 0);
            chk("found", int'(found), e.found);
            chk("steps", int'(steps), e.steps);
            chk("latency", cyc - e.start_cyc, e.steps * P);
          end
        end
      end
      prev_term = done || err;
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      chk("timeout_waiting_for_dut", int'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  task automatic run_search(input int a, input bit fb);
    @(negedge clk);
    hidden    = a;
    force_bad = fb;
    exp_q.push_back(model(a, fb, cyc + 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty();
  endtask

  initial begin : driver
    exp_t r, e1, e2;
    int   s;
    cyc = 0; n_checks = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; hidden = 0; force_bad = 1'b0;
    r = model(0, 0, 2);
    r.kind = K_RESET;
    exp_q.push_back(r);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_empty();

    run_search(2, 0);
    run_search(3, 0);
    run_search(0, 0);
    run_search(1, 0);
    run_search(1, 1);
    force_bad = 1'b0;

    // reset during the second WAIT of a=3, then a clean re-run
    @(negedge clk);
    hidden = 3;
    s = cyc + 1;
    exp_q.push_back(model(3, 0, s));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    r = model(0, 0, cyc + 1);
    r.kind = K_RESET;
    exp_q.push_back(r);
    @(negedge clk);
    rst_n = 1'b1;
    wait_empty();
    run_search(3, 0);

    // start held high: ignored while busy, restarts right after DONE
    @(negedge clk);
    hidden = 2;
    s  = cyc + 1;
    e1 = model(2, 0, s);
    e2 = model(2, 0, s + e1.steps * P + 1);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    start = 1'b1;
    for (int i = 0; i < 40 && cyc < e2.start_cyc; i++) @(negedge clk);
    start = 1'b0;
    wait_empty();

    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_search(int'($urandom_range(0, (1 << W) - 1)), ($urandom_range(0, 5) == 0));
    end
    force_bad = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", int'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rgb_cmp_search
`default_nettype wire
